// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : operand_stack
// Description : Single-clock LIFO operand stack for the CPU control FSM.
//               Exposes TOS/NOS combinationally from registered state.
//               Keeps sticky overflow/underflow flags and supports an
//               atomic replace-TOS operation (push and pop together).
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_top,
    output logic [DATA_W-1:0] data_next,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0]   c_depth   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_idx_one = PTR_W'(1);
    localparam logic [PTR_W-1:0] c_idx_two = PTR_W'(2);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic [PTR_W-1:0]  w_tos_idx;
    logic [PTR_W-1:0]  w_nos_idx;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W:0]    w_count_nxt;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // Low pointer bits wrap naturally: at count==DEPTH they are 0, so
    // subtracting 1/2 still lands on DEPTH-1/DEPTH-2.
    assign w_tos_idx = r_count[PTR_W-1:0] - c_idx_one;
    assign w_nos_idx = r_count[PTR_W-1:0] - c_idx_two;

    // Decode the requested operation into a write, a new count and error events.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = r_count[PTR_W-1:0];
        w_count_nxt = r_count;
        w_ovf_evt   = 1'b0;
        w_unf_evt   = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (w_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_count + c_cnt_one;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_count_nxt = r_count - c_cnt_one;
                end
            end
            2'b11: begin
                // Replace TOS; on an empty stack the value is still pushed
                // but the missing operand is reported as an underflow.
                w_wr_en = 1'b1;
                if (w_empty) begin
                    w_wr_idx    = '0;
                    w_count_nxt = c_cnt_one;
                    w_unf_evt   = 1'b1;
                end else begin
                    w_wr_idx = w_tos_idx;
                end
            end
            default: begin
            end
        endcase
    end

    // Entry storage; contents need no reset because invalid slots are masked.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    // Stack pointer and sticky error flags; a new error beats clear_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_evt | (r_overflow  & ~clear_err);
            r_underflow <= w_unf_evt | (r_underflow & ~clear_err);
        end
    end

    assign data_top  = (r_count >= c_cnt_one) ? r_mem[w_tos_idx] : '0;
    assign data_next = (r_count >  c_cnt_one) ? r_mem[w_nos_idx] : '0;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_stack
// Description : Self-checking bench for operand_stack. A behavioural stack
//               model predicts the state after each cycle; the prediction is
//               queued when stimulus is driven and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stack;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;

    logic              clk;
    logic              reset;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              clear_err;
    logic [DATA_W-1:0] data_top;
    logic [DATA_W-1:0] data_next;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    operand_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .clear_err (clear_err),
        .data_top  (data_top),
        .data_next (data_next),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int top;
        int nxt;
        bit emp;
        bit ful;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference stack state
    int m_mem [DEPTH];
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge.
    task automatic model_step(input bit rst, input bit ps, input bit pp,
                              input int din, input bit clr);
        bit ovf_e;
        bit unf_e;
        ovf_e = 1'b0;
        unf_e = 1'b0;
        if (rst) begin
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        if (ps && !pp) begin
            if (m_cnt < DEPTH) begin
                m_mem[m_cnt] = din;
                m_cnt++;
            end else begin
                ovf_e = 1'b1;
            end
        end else if (!ps && pp) begin
            if (m_cnt > 0) m_cnt--;
            else unf_e = 1'b1;
        end else if (ps && pp) begin
            if (m_cnt >= 1) begin
                m_mem[m_cnt-1] = din;
            end else begin
                m_mem[0] = din;
                m_cnt    = 1;
                unf_e    = 1'b1;
            end
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_ovf = m_ovf | ovf_e;
        m_unf = m_unf | unf_e;
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.cnt = m_cnt;
        e.top = (m_cnt >= 1) ? m_mem[m_cnt-1] : 0;
        e.nxt = (m_cnt >= 2) ? m_mem[m_cnt-2] : 0;
        e.emp = (m_cnt == 0);
        e.ful = (m_cnt == DEPTH);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    // Drive one cycle of stimulus, queue the prediction, then compare after the edge.
    task automatic cyc(input bit ps, input bit pp, input int din,
                       input bit clr, input bit rst);
        exp_t e;
        reset     = rst;
        push      = ps;
        pop       = pp;
        data_in   = din[DATA_W-1:0];
        clear_err = clr;
        model_step(rst, ps, pp, din, clr);
        sb_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("count",     int'(count),     e.cnt);
        check_val("data_top",  int'(data_top),  e.top);
        check_val("data_next", int'(data_next), e.nxt);
        check_val("empty",     int'(empty),     int'(e.emp));
        check_val("full",      int'(full),      int'(e.ful));
        check_val("overflow",  int'(overflow),  int'(e.ovf));
        check_val("underflow", int'(underflow), int'(e.unf));
        reset     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = '0;
        clear_err = 1'b0;
        @(negedge clk);

        // Reset state
        cyc(0, 0, 0, 0, 1);
        check_val("rst_empty", int'(empty), 1);
        check_val("rst_top",   int'(data_top), 0);

        // Three pushes
        cyc(1, 0, 'h11, 0, 0);
        cyc(1, 0, 'h22, 0, 0);
        cyc(1, 0, 'h33, 0, 0);
        check_val("p3_count", int'(count), 3);
        check_val("p3_top",   int'(data_top), 'h33);
        check_val("p3_next",  int'(data_next), 'h22);

        // Drain past empty
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check_val("pop2_top",  int'(data_top), 'h11);
        check_val("pop2_next", int'(data_next), 0);
        cyc(0, 1, 0, 0, 0);
        check_val("pop3_empty", int'(empty), 1);
        cyc(0, 1, 0, 0, 0);
        check_val("unf_set", int'(underflow), 1);

        // Sticky clear, then clear colliding with a fresh underflow
        cyc(0, 0, 0, 1, 0);
        check_val("unf_clr", int'(underflow), 0);
        cyc(0, 1, 0, 1, 0);
        check_val("unf_wins", int'(underflow), 1);
        cyc(0, 0, 0, 1, 0);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, i, 0, 0);
        check_val("fill_full", int'(full), 1);
        check_val("fill_top",  int'(data_top), 'h0F);
        cyc(1, 0, 'hAA, 0, 0);
        check_val("ovf_set",   int'(overflow), 1);
        check_val("ovf_top",   int'(data_top), 'h0F);
        check_val("ovf_count", int'(count), 16);
        cyc(0, 1, 0, 0, 0);
        check_val("ovf_pop_top", int'(data_top), 'h0E);

        // Replace TOS while full raises no flag
        cyc(1, 0, 'h0F, 1, 0);
        cyc(1, 1, 'h5A, 0, 0);
        check_val("rep_full_count", int'(count), 16);
        check_val("rep_full_ovf",   int'(overflow), 0);
        check_val("rep_full_top",   int'(data_top), 'h5A);

        // Replace TOS on a two-entry stack
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 'h05, 0, 0);
        cyc(1, 0, 'h07, 0, 0);
        cyc(1, 1, 'h0C, 0, 0);
        check_val("rep_count", int'(count), 2);
        check_val("rep_top",   int'(data_top), 'h0C);
        check_val("rep_next",  int'(data_next), 'h05);

        // Binary-op sequence: pop, then push result with pop
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 'h11, 0, 0);
        check_val("binop_count", int'(count), 1);
        check_val("binop_top",   int'(data_top), 'h11);

        // Push+pop on empty: value lands, underflow raised
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 'h99, 0, 0);
        check_val("pp_empty_count", int'(count), 1);
        check_val("pp_empty_unf",   int'(underflow), 1);

        // Reset wins over a coincident push at count=5
        for (int i = 0; i < 4; i++) cyc(1, 0, 'h40 + i, 0, 0);
        cyc(1, 0, 'h77, 0, 1);
        check_val("rst_push_count", int'(count), 0);
        check_val("rst_push_unf",   int'(underflow), 0);
        check_val("rst_push_top",   int'(data_top), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1),
                int'($urandom_range(0, 255)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
